// File: rtl/ysyx_22040931_ifetch.sv
// Instruction fetch: one PC per handshake, single outstanding imem read, {pc, instr} held for ID.
// Accept-to-id_valid is 3 cycles with ideal memory; if_ready falls while HOLD is stalled by id_ready or during flush.
module ysyx_22040931_ifetch #(
  parameter int PC_W   = 64,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              pc_valid,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_ready,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [31:0]       id_instr,
  output logic              id_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              drop_q, drop_d;
  logic [PC_W-1:0]   id_pc_q, id_pc_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic              id_err_q, id_err_d;
  logic              accept;
  logic [31:0]       resp_instr;

  assign if_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_HOLD) & id_ready));
  assign accept   = pc_valid & if_ready;

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = {pc_q[PC_W-1:3], 3'b000};
  assign id_valid       = (state_q == S_HOLD);
  assign id_pc          = id_pc_q;
  assign id_instr       = id_instr_q;
  assign id_err         = id_err_q;

  // A faulting fetch is handed to ID as a NOP tagged with id_err.
  assign resp_instr = imem_resp_err ? 32'h0000_0013
                    : (pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0]);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_err_d   = id_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          pc_d    = if_pc;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Request cannot be retracted; remember to discard its response.
        if (flush) drop_d = 1'b1;
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            id_pc_d    = pc_q;
            id_instr_d = resp_instr;
            id_err_d   = imem_resp_err;
            state_d    = S_HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (id_ready) begin
          if (accept) begin
            pc_d    = if_pc;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      drop_q     <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_err_q   <= id_err_d;
    end
  end

endmodule

// File: doc/ysyx_22040931_ifetch.md
# ysyx_22040931_ifetch

Instruction-fetch access unit directly downstream of the PC/predictor stage. It accepts one PC per handshake, issues a single-outstanding read to instruction memory, extracts the 32-bit instruction from the 64-bit response, and holds `{pc, instr}` for the ID stage under a valid/ready handshake. Its `if_ready` output backpressures PC generation, and `flush` discards in-flight work after a branch mispredict.

## Interface
Parameters:
- `PC_W`, 64: PC and memory address width.
- `DATA_W`, 64: instruction-memory response width. Fixed at 64.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `flush` in 1: mispredict/redirect; kill the current fetch.
- `pc_valid` in 1: a PC is offered by the PC stage.
- `if_pc` in PC_W: offered PC, 4-byte aligned.
- `if_ready` out 1: this block accepts `if_pc` this cycle.
- `imem_req_valid` out 1: read request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out PC_W: `{pc_q[PC_W-1:3], 3'b000}`.
- `imem_resp_valid` in 1: read data valid, one cycle per request.
- `imem_resp_data` in DATA_W: 8-byte-aligned read data.
- `imem_resp_err` in 1: access fault, qualified by `imem_resp_valid`.
- `id_valid` out 1: `id_pc`/`id_instr` are valid.
- `id_ready` in 1: the ID stage consumes them.
- `id_pc` out PC_W: PC of the held instruction.
- `id_instr` out 32: held instruction.
- `id_err` out 1: the held instruction faulted.

## Operation
- `accept = pc_valid & if_ready`.
- `if_ready = ~flush & (state==IDLE | (state==HOLD & id_ready))`. This is combinational.
- States:
  - IDLE: on `accept`, load `pc_q <= if_pc` and go to REQ.
  - REQ: `imem_req_valid=1`. The request stays stable until `imem_req_ready`. On the handshake, go to WAIT.
  - WAIT: on `imem_resp_valid`:
    - If `drop` is set or `flush` is high, clear `drop` and go to IDLE.
    - Otherwise, load the ID registers and go to HOLD.
  - HOLD: `id_valid=1`. On `id_ready`:
    - If `accept` occurs in the same cycle, load the new `pc_q` and go to REQ.
    - Otherwise, go to IDLE.
- Instruction select: `id_instr = pc_q[2] ? data[63:32] : data[31:0]`.
- Error handling: when `imem_resp_err` is high, `id_instr = 32'h00000013` (NOP) and `id_err = 1`.
- Flush behaviour by state:
  - IDLE: no accept.
  - REQ: the request still completes (no valid retraction) and `drop` is set. WAIT then discards the response.
  - WAIT: `drop` is set. If the response arrives in the same cycle, it is discarded directly.
  - HOLD: go to IDLE; `id_valid` is low the next cycle.
- `flush` has priority over `accept` and `id_ready`.
- At most one request is outstanding. A new request is never issued while `drop` is pending a response.

## Timing
- Reset values: state IDLE; `id_valid` 0; `id_pc` 0; `id_instr` 0; `id_err` 0; `drop` 0; `pc_q` 0; `imem_req_valid` 0.
- `if_ready` is 1 once reset is released, provided `flush` is low.
- `imem_req_valid` and `id_valid` are pure state decodes (registered). `if_ready` is the only combinational path, from `flush` and `id_ready`.
- Latency with ideal memory (ready=1, response one cycle after the handshake):
  - accept at cycle t → request at t+1 → response at t+2 → `id_valid` at t+3.
- Throughput: one instruction per 3 cycles with ideal memory, since back-to-back issue is only from HOLD.
- Reset mid-transaction: return to IDLE immediately. A stale response arriving after reset is ignored because state is IDLE.
- `imem_resp_valid` outside WAIT is ignored. The memory never does this by protocol.

## Test plan
- Basic fetch, `pc_valid=1` for one cycle:
  - Stimulus: `if_pc=0x80000004`, memory data `0x00100093_00000013`.
  - Required response: `imem_req_addr=0x80000000`, `id_instr=0x00100093`, `id_pc=0x80000004`, `id_valid` 3 cycles after accept.
- Backpressure: hold `id_ready=0` for 5 cycles in HOLD.
  - Required response: `id_*` stable and `if_ready=0` throughout.
  - Raise `id_ready` with `pc_valid=1`: REQ for the next PC on the following cycle.
- Memory stall: `imem_req_ready=0` for 4 cycles.
  - Required response: `imem_req_valid` and `imem_req_addr` stable across all 4 cycles.
- Flush in WAIT: pulse `flush` one cycle before `imem_resp_valid`.
  - Required response: no `id_valid`, return to IDLE.
  - Next accept of `0x80000100` delivers the instruction for that PC only.
- Flush in HOLD and flush coincident with the response:
  - Required response: `id_valid` falls the next cycle and `if_ready=0` during the flush cycle.
- Error plus async reset:
  - `imem_resp_err=1` → `id_instr=0x00000013`, `id_err=1`.
  - `reset` asserted mid-WAIT clears `id_valid` and `imem_req_valid` before the next clock edge.
